// File: rtl/seq_mult16_pkg.sv
// Shared constants for the sequential 16x16 multiplier and its adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_mult16_pkg;

    // Operand width is tied to the 16-bit ripple adder datapath
    localparam int WIDTH  = 16;
    localparam int PROD_W = 2 * WIDTH;
    localparam int CNT_W  = 5;
    localparam int ITER   = WIDTH;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Partial-product addend: the multiplicand when the current multiplier bit is set
    function automatic logic [WIDTH-1:0] pp_addend(input logic [WIDTH-1:0] m,
                                                   input logic             qbit);
        return qbit ? m : '0;
    endfunction

endpackage

// File: rtl/seq_mult16_adder16.sv
// 16-bit unsigned ripple-carry adder; carry-out is the 17th sum bit.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module adder16
    import seq_mult16_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = 1'b0;

    // One full adder per bit, carry rippling from bit 0 upward
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/seq_mult16.sv
// Sequential unsigned 16x16->32 shift-and-add multiplier, one partial product per clock.
// Latency: 17 cycles from accepted start to the done pulse; one result per 17 cycles back-to-back.
// Backpressure: start is only accepted while ready (IDLE or DONE); it is ignored during RUN.
module seq_mult16
    import seq_mult16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] p
);

    state_t           state;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             accept;
    logic             last_iter;

    assign addend    = pp_addend(m, q[0]);
    assign ready     = (state == IDLE) || (state == DONE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign accept    = ready && start;
    assign last_iter = (count == CNT_W'(ITER - 1));
    assign p         = {acc, q};

    adder16 u_adder (
        .a    (acc),
        .b    (addend),
        .s    (sum),
        .cout (cout)
    );

    // Control FSM: capture on accepted start, count 16 RUN edges, pulse DONE for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state <= RUN;
                        count <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    count <= count + CNT_W'(1);
                    if (last_iter) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // Datapath: load operands on accept, otherwise shift {cout,sum,Q[15:1]} into {A,Q} while running
    always_ff @(posedge clk) begin
        if (rst) begin
            m   <= '0;
            acc <= '0;
            q   <= '0;
        end else if (accept) begin
            m   <= a;
            acc <= '0;
            q   <= b;
        end else if (state == RUN) begin
            // Carry-out becomes the new top bit of A so no sum bit is ever lost
            acc <= {cout, sum[WIDTH-1:1]};
            q   <= {sum[0], q[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_seq_mult16.sv
module tb_seq_mult16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] p;

    int passed;
    int total;
    int done_cnt;

    seq_mult16 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert start for exactly one edge with the given operands
    task automatic pulse_start(input logic [15:0] av, input logic [15:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the accepting edge; n counts edges from start to visible done
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
        total++; if (busy  !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);  else passed++;
        total++; if (done  !== 1'b0) $display("FAIL reset_done got %b want 0", done);  else passed++;
        total++; if (p !== 32'h0) $display("FAIL reset_p got %h want 00000000", p); else passed++;
    endtask

    task automatic test_basic();
        int n;
        int busy_cycles;
        pulse_start(16'd3, 16'd5);
        total++; if (busy !== 1'b1 || ready !== 1'b0)
            $display("FAIL basic_busy got busy=%b ready=%b want 1/0", busy, ready); else passed++;
        busy_cycles = 0;
        n = 1;
        while (done !== 1'b1 && n < 60) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            n++;
        end
        total++; if (busy_cycles != 16) $display("FAIL basic_busy_cycles got %0d want 16", busy_cycles); else passed++;
        total++; if (n != 17) $display("FAIL basic_latency got %0d want 17", n); else passed++;
        total++; if (p !== 32'h0000000F) $display("FAIL basic_p got %h want 0000000f", p); else passed++;
        total++; if (ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL basic_done_ready got ready=%b busy=%b want 1/0", ready, busy); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else passed++;
        total++; if (p !== 32'h0000000F || ready !== 1'b1)
            $display("FAIL basic_idle_hold got p=%h ready=%b want 0000000f/1", p, ready); else passed++;
    endtask

    task automatic test_max();
        int n;
        pulse_start(16'hFFFF, 16'hFFFF);
        wait_done(n);
        total++; if (n != 17) $display("FAIL max_latency got %0d want 17", n); else passed++;
        total++; if (p !== 32'hFFFE0001) $display("FAIL max_p got %h want fffe0001", p); else passed++;
        tick();
    endtask

    task automatic test_zero();
        int n;
        pulse_start(16'h1234, 16'h0000);
        wait_done(n);
        total++; if (n != 17) $display("FAIL zero_b_latency got %0d want 17", n); else passed++;
        total++; if (p !== 32'h0) $display("FAIL zero_b_p got %h want 00000000", p); else passed++;
        tick();
        pulse_start(16'h0000, 16'hABCD);
        wait_done(n);
        total++; if (n != 17) $display("FAIL zero_a_latency got %0d want 17", n); else passed++;
        total++; if (p !== 32'h0) $display("FAIL zero_a_p got %h want 00000000", p); else passed++;
        tick();
    endtask

    task automatic test_ignore_start();
        int n;
        int d0;
        d0 = done_cnt;
        pulse_start(16'h00FF, 16'h0101);
        n = 1;
        while (n < 5) begin
            tick();
            n++;
        end
        a     = 16'd7;
        b     = 16'd9;
        start = 1'b1;
        tick();
        n++;
        start = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL ignore_still_busy got %b want 1", busy); else passed++;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        total++; if (n != 17) $display("FAIL ignore_latency got %0d want 17", n); else passed++;
        total++; if (p !== 32'h0000FFFF) $display("FAIL ignore_p got %h want 0000ffff", p); else passed++;
        repeat (4) tick();
        total++; if (done_cnt - d0 != 1) $display("FAIL ignore_done_count got %0d want 1", done_cnt - d0); else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        int d0;
        pulse_start(16'h1234, 16'h5678);
        repeat (7) tick();
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL midrst_state got ready=%b busy=%b want 1/0", ready, busy); else passed++;
        total++; if (p !== 32'h0) $display("FAIL midrst_p got %h want 00000000", p); else passed++;
        repeat (20) tick();
        total++; if (done_cnt != d0) $display("FAIL midrst_no_done got %0d pulses want 0", done_cnt - d0); else passed++;
        pulse_start(16'd2, 16'd2);
        wait_done(n);
        total++; if (p !== 32'd4) $display("FAIL midrst_after_p got %0d want 4", p); else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        a     = 16'd6;
        b     = 16'd7;
        start = 1'b1;
        tick();
        a = 16'd100;
        b = 16'd200;
        wait_done(n);
        total++; if (n != 17) $display("FAIL b2b_first_latency got %0d want 17", n); else passed++;
        total++; if (p !== 32'd42) $display("FAIL b2b_first_p got %0d want 42", p); else passed++;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_restart got busy=%b done=%b want 1/0", busy, done); else passed++;
        wait_done(n);
        total++; if (n != 17) $display("FAIL b2b_second_latency got %0d want 17", n); else passed++;
        total++; if (p !== 32'd20000) $display("FAIL b2b_second_p got %0d want 20000", p); else passed++;
        tick();
        total++; if (done !== 1'b0 || ready !== 1'b1)
            $display("FAIL b2b_end got done=%b ready=%b want 0/1", done, ready); else passed++;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
